t09_buzzer_driver: RTL and testbench

//  Downstream consumer of the tone oscillator's at_max pulse train. Each
//  at_max pulse toggles an internal square wave. The wave is gated by a

---
 rtl/t09_pkg.sv | 26 ++
 rtl/t09_pwm_gate.sv | 39 +++
 rtl/t09_buzzer_driver.sv | 140 ++++++++++++++
 tb/tb_t09_buzzer_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/t09_pkg.sv
// ----------------------------------------------------------------------------
// t09_pkg
//   Shared types and default sizing for the piezo buzzer driver.
//
//   Contents:
//     t09_buz_state_t     tone tracking FSM states (IDLE, PLAY, RELEASE)
//     SILENCE_LIMIT_DEF   cycles without an at_max pulse before a tone ends.
//                         Must exceed the longest tone period (157 cycles).
//     RELEASE_CYCLES_DEF  cycles the output is held low after a tone ends
//     PWM_BITS_DEF        width of the volume input and PWM counter
//     SIL_W_DEF           silence counter width; must hold SILENCE_LIMIT_DEF
// ----------------------------------------------------------------------------
package t09_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } t09_buz_state_t;

    localparam int unsigned SILENCE_LIMIT_DEF  = 512;
    localparam int unsigned RELEASE_CYCLES_DEF = 64;
    localparam int unsigned PWM_BITS_DEF       = 3;
    localparam int unsigned SIL_W_DEF          = 10;

endpackage

// File: rtl/t09_pwm_gate.sv
// ----------------------------------------------------------------------------
// t09_pwm_gate
//   Free-running PWM counter plus duty compare used as the volume gate.
//
//   Ports:
//     clk    in   1         system clock
//     nRst   in   1         asynchronous active-low reset
//     vol_q  in   PWM_BITS  latched volume of the current tone
//     gate   out  1         1 while the current PWM slot is "on"
//
//   The duty is vol_q / 2^PWM_BITS, except all-ones, which is forced to
//   100 % so that full volume gives an ungated square wave.
// ----------------------------------------------------------------------------
module t09_pwm_gate
    import t09_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic [PWM_BITS-1:0] vol_q,
    output logic                gate
);

    logic [PWM_BITS-1:0] pwm_cnt;

    // Wraps naturally from all-ones back to zero.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    // vol_q == 0 never satisfies the compare, so the gate stays closed.
    assign gate = (&vol_q) | (pwm_cnt < vol_q);

endmodule

// File: rtl/t09_buzzer_driver.sv
// ----------------------------------------------------------------------------
// t09_buzzer_driver
//   Turns the tone oscillator's at_max pulse train into a piezo drive.
//   Each at_max pulse toggles an internal square wave. The wave is gated by
//   a volume PWM and a mute input. A small FSM tracks tone start and end and
//   forces a clean low release once the pulse train stops.
//
//   Ports:
//     clk          in   1         system clock
//     nRst         in   1         asynchronous active-low reset
//     at_max       in   1         1-cycle pulse, one pulse per half-period
//     mute         in   1         level; 1 forces sound_out low, FSM runs on
//     volume       in   PWM_BITS  duty select, latched on tone start
//     sound_out    out  1         registered piezo drive
//     tone_active  out  1         registered; 1 while the FSM is in PLAY
//
//   Timing: at_max sampled at edge n updates the wave at edge n, and
//   sound_out follows at edge n+1. tone_active is registered from the
//   next state, so it rises on the same edge the wave first goes high.
// ----------------------------------------------------------------------------
module t09_buzzer_driver
    import t09_pkg::*;
#(
    parameter int unsigned SILENCE_LIMIT  = SILENCE_LIMIT_DEF,
    parameter int unsigned SIL_W          = SIL_W_DEF,
    parameter int unsigned RELEASE_CYCLES = RELEASE_CYCLES_DEF,
    parameter int unsigned PWM_BITS       = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                at_max,
    input  logic                mute,
    input  logic [PWM_BITS-1:0] volume,
    output logic                sound_out,
    output logic                tone_active
);

    localparam int unsigned REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

    localparam logic [SIL_W-1:0] SIL_LAST = SIL_W'(SILENCE_LIMIT - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_CYCLES - 1);

    t09_buz_state_t      state_q, state_d;
    logic                wave_q, wave_d;
    logic [SIL_W-1:0]    sil_cnt_q, sil_cnt_d;
    logic [REL_W-1:0]    rel_cnt_q, rel_cnt_d;
    logic [PWM_BITS-1:0] vol_q, vol_d;
    logic                sound_d;
    logic                active_d;
    logic                gate;

    t09_pwm_gate #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_gate (
        .clk   (clk),
        .nRst  (nRst),
        .vol_q (vol_q),
        .gate  (gate)
    );

    // Next-state logic. Tone start behaves identically from IDLE and from
    // RELEASE, so a pulse arriving mid-release simply restarts the tone.
    always_comb begin
        state_d   = state_q;
        wave_d    = wave_q;
        sil_cnt_d = sil_cnt_q;
        rel_cnt_d = rel_cnt_q;
        vol_d     = vol_q;

        unique case (state_q)
            IDLE: begin
                wave_d = 1'b0;
                if (at_max) begin
                    state_d   = PLAY;
                    wave_d    = 1'b1;
                    sil_cnt_d = '0;
                    vol_d     = volume;
                end
            end

            PLAY: begin
                // A pulse in the limit cycle wins and keeps the tone alive.
                if (at_max) begin
                    wave_d    = ~wave_q;
                    sil_cnt_d = '0;
                end else if (sil_cnt_q == SIL_LAST) begin
                    state_d   = RELEASE;
                    wave_d    = 1'b0;
                    rel_cnt_d = '0;
                end else begin
                    sil_cnt_d = sil_cnt_q + 1'b1;
                end
            end

            RELEASE: begin
                wave_d = 1'b0;
                if (at_max) begin
                    state_d   = PLAY;
                    wave_d    = 1'b1;
                    sil_cnt_d = '0;
                    vol_d     = volume;
                end else if (rel_cnt_q == REL_LAST) begin
                    state_d = IDLE;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                wave_d  = 1'b0;
            end
        endcase

        // Output drive uses the current (registered) wave and state.
        sound_d  = wave_q & gate & ~mute & (state_q == PLAY);
        active_d = (state_d == PLAY);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            wave_q      <= 1'b0;
            sil_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            vol_q       <= '0;
            sound_out   <= 1'b0;
            tone_active <= 1'b0;
        end else begin
            state_q     <= state_d;
            wave_q      <= wave_d;
            sil_cnt_q   <= sil_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            vol_q       <= vol_d;
            sound_out   <= sound_d;
            tone_active <= active_d;
        end
    end

endmodule

// File: tb/tb_t09_buzzer_driver.sv
// ----------------------------------------------------------------------------
// tb_t09_buzzer_driver
//   Directed bench for t09_buzzer_driver. Every clock an expected output
//   pair from a behavioural model is pushed to a scoreboard and popped
//   when the DUT output is sampled one unit after the edge. Directed
//   checks on tone timing, duty and boundaries run alongside.
// ----------------------------------------------------------------------------
module tb_t09_buzzer_driver;

    logic       clk    = 1'b0;
    logic       nRst   = 1'b0;
    logic       at_max = 1'b0;
    logic       mute   = 1'b0;
    logic [2:0] volume = 3'd0;
    logic       sound_out;
    logic       tone_active;

    always #5 clk = ~clk;

    t09_buzzer_driver dut (
        .clk         (clk),
        .nRst        (nRst),
        .at_max      (at_max),
        .mute        (mute),
        .volume      (volume),
        .sound_out   (sound_out),
        .tone_active (tone_active)
    );

    typedef struct packed {
        logic so;
        logic ta;
    } exp_t;

    exp_t sb[$];

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: 0 = IDLE, 1 = PLAY, 2 = RELEASE
    int   m_state;
    logic m_wave;
    int   m_sil;
    int   m_rel;
    int   m_pwm;
    int   m_vol;
    logic m_so;
    logic m_ta;

    logic obs_so;
    logic obs_ta;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_wave  = 1'b0;
        m_sil   = 0;
        m_rel   = 0;
        m_pwm   = 0;
        m_vol   = 0;
        m_so    = 1'b0;
        m_ta    = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the current inputs.
    task automatic model_step();
        int   ns;
        logic gate;
        gate = (m_vol == 7) || (m_pwm < m_vol);
        m_so = m_wave & gate & ~mute & (m_state == 1);
        ns   = m_state;
        if (m_state == 0) begin
            m_wave = 1'b0;
            if (at_max) begin
                ns = 1; m_wave = 1'b1; m_sil = 0; m_vol = int'(volume);
            end
        end else if (m_state == 1) begin
            if (at_max) begin
                m_wave = ~m_wave; m_sil = 0;
            end else if (m_sil == 511) begin
                ns = 2; m_wave = 1'b0; m_rel = 0;
            end else begin
                m_sil = m_sil + 1;
            end
        end else begin
            m_wave = 1'b0;
            if (at_max) begin
                ns = 1; m_wave = 1'b1; m_sil = 0; m_vol = int'(volume);
            end else if (m_rel == 63) begin
                ns = 0;
            end else begin
                m_rel = m_rel + 1;
            end
        end
        m_ta    = (ns == 1);
        m_state = ns;
        m_pwm   = (m_pwm + 1) % 8;
    endtask

    task automatic tick(input string tag);
        exp_t e;
        model_step();
        e.so = m_so;
        e.ta = m_ta;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e      = sb.pop_front();
        obs_so = sound_out;
        obs_ta = tone_active;
        check_bit({tag, "/sound_out"}, obs_so, e.so);
        check_bit({tag, "/tone_active"}, obs_ta, e.ta);
    endtask

    task automatic pulse(input string tag);
        at_max = 1'b1;
        tick(tag);
        at_max = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) tick(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        // 1. Reset then idle
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_bit("rst_sound_out", sound_out, 1'b0);
            check_bit("rst_tone_active", tone_active, 1'b0);
        end
        nRst = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 1000; i++) begin
            tick("t1_idle");
            if (obs_so || obs_ta) cnt++;
        end
        check_int("t1_idle_highs", cnt, 0);

        // 2. Full-volume tone, ten pulses 90 cycles apart
        volume = 3'd7;
        for (int i = 0; i < 10; i++) begin
            pulse("t2_tone");
            if (i == 0) check_bit("t2_active_rise", obs_ta, 1'b1);
            tick("t2_tone");
            check_bit("t2_wave_phase", obs_so, (i % 2) == 0);
            if (i != 9) idle(88, "t2_tone");
        end
        cnt = 0;
        for (int i = 0; i < 600; i++) begin
            tick("t2_tail");
            if (obs_ta) cnt++;
        end
        check_int("t2_active_after_last", cnt, 510);

        // 3. PWM duty at volume 2, then a silent tone at volume 0
        volume = 3'd2;
        pulse("t3_pwm");
        tick("t3_pwm");
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            tick("t3_pwm");
            if (obs_so) cnt++;
        end
        check_int("t3_duty_2of8", cnt, 16);
        idle(600, "t3_tail");
        volume = 3'd0;
        cnt    = 0;
        for (int i = 0; i < 4; i++) begin
            pulse("t3_vol0");
            if (obs_so) cnt++;
            for (int j = 0; j < 49; j++) begin
                tick("t3_vol0");
                if (obs_so) cnt++;
            end
        end
        check_int("t3_vol0_silent", cnt, 0);
        check_bit("t3_vol0_active", obs_ta, 1'b1);
        idle(600, "t3_tail2");

        // 4. Boundaries: pulse at sil_cnt==511, pulse in release cycle 30
        volume = 3'd7;
        pulse("t4_start");
        idle(511, "t4_wait");
        pulse("t4_limit_pulse");
        check_bit("t4_limit_stays_play", obs_ta, 1'b1);
        idle(511, "t4_wait2");
        check_bit("t4_still_play_511", obs_ta, 1'b1);
        tick("t4_to_release");
        check_bit("t4_release_entered", obs_ta, 1'b0);
        idle(30, "t4_release");
        pulse("t4_rel_pulse");
        check_bit("t4_rel_to_play", obs_ta, 1'b1);
        tick("t4_rel_wave");
        check_bit("t4_rel_wave_high", obs_so, 1'b1);

        // 5. Mute mid-tone keeps the wave running; volume change mid-tone
        idle(5, "t5_pre");
        mute = 1'b1;
        tick("t5_mute");
        check_bit("t5_mute_low", obs_so, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse("t5_muted");
            idle(19, "t5_muted");
        end
        mute = 1'b0;
        tick("t5_unmute");
        check_bit("t5_unmuted_wave_low", obs_so, 1'b0);
        pulse("t5_unmute_pulse");
        tick("t5_unmute_pulse");
        check_bit("t5_unmuted_wave_high", obs_so, 1'b1);
        idle(600, "t5_tail");
        volume = 3'd2;
        pulse("t5_vol");
        volume = 3'd5;
        tick("t5_vol");
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            tick("t5_vol");
            if (obs_so) cnt++;
        end
        check_int("t5_duty_unchanged", cnt, 16);
        idle(600, "t5_tail2");

        // 6. Asynchronous reset mid-PLAY without a clock edge
        volume = 3'd7;
        pulse("t6_start");
        idle(3, "t6_play");
        check_bit("t6_sound_before", obs_so, 1'b1);
        #2;
        nRst = 1'b0;
        #1;
        check_bit("t6_async_sound_out", sound_out, 1'b0);
        check_bit("t6_async_tone_active", tone_active, 1'b0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_bit("t6_hold_sound_out", sound_out, 1'b0);
            check_bit("t6_hold_tone_active", tone_active, 1'b0);
        end
        nRst = 1'b1;
        idle(10, "t6_after");
        check_int("t6_scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
